// File: rtl/disparity_pkg.sv
// Shared types and width helpers for the block-matching disparity engine.
package disparity_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_L,
      LOAD_R,
      SETUP,
      ACCUM,
      COMPARE,
      EMIT
   } state_t;

   // Never returns less than 1 so single-entry ranges still get a usable bus.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width = width + 1;
      return width;
   endfunction

   function automatic int acc_width(input int pix_w, input int half_block);
      return pix_w + clog2((2 * half_block + 1) * (2 * half_block + 1));
   endfunction

endpackage

// File: rtl/sad_accum.sv
// Absolute-difference accumulator; i_en marks the cycle a read pair is issued,
// the data arrives one cycle later from the frame RAMs.
module sad_accum
   import disparity_pkg::*;
#(
   parameter int PIX_W      = 8,
   parameter int HALF_BLOCK = 3,
   parameter int ACC_W      = acc_width(PIX_W, HALF_BLOCK)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic [PIX_W-1:0] i_left,
   input  logic [PIX_W-1:0] i_right,
   output logic [ACC_W-1:0] o_sad
);

   logic             r_valid;
   logic [ACC_W-1:0] r_acc;
   logic [PIX_W-1:0] w_diff;

   assign w_diff = (i_left > i_right) ? (i_left - i_right) : (i_right - i_left);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_acc   <= '0;
      end else begin
         r_valid <= i_en;
         if (i_clear) begin
            r_acc <= '0;
         end else if (r_valid) begin
            r_acc <= r_acc + ACC_W'(w_diff);
         end
      end
   end

   assign o_sad = r_acc;

endmodule

// File: rtl/disparity_sad_engine.sv
// Loads a left/right frame pair from a pixel stream, then emits one
// SAD-minimising disparity per pixel in raster order with valid/ready output.
module disparity_sad_engine
   import disparity_pkg::*;
#(
   parameter int WIDTH        = 46,
   parameter int HEIGHT       = 30,
   parameter int PIX_W        = 8,
   parameter int HALF_BLOCK   = 3,
   parameter int SEARCH_RANGE = 50,
   parameter int DISP_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [PIX_W-1:0]  image_data,
   input  logic              buffer_ready,
   output logic              image_sel,
   output logic              load_ready,
   output logic [DISP_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              disp_ready,
   output logic              disp_last,
   output logic              idle
);

   localparam int DEPTH  = WIDTH * HEIGHT;
   localparam int ADDR_W = clog2(DEPTH);
   localparam int ROW_W  = clog2(HEIGHT);
   localparam int COL_W  = clog2(WIDTH);
   localparam int ACC_W  = acc_width(PIX_W, HALF_BLOCK);

   state_t            r_state;
   logic              r_image_sel, r_load_ready, r_disp_valid, r_disp_last, r_idle;
   logic [DISP_W-1:0] r_disp_data;
   logic [ADDR_W-1:0] r_load_addr;
   logic [ROW_W-1:0]  r_row, r_minr, r_maxr, r_y;
   logic [COL_W-1:0]  r_col, r_minc, r_maxc, r_x;
   logic [DISP_W-1:0] r_d, r_maxd, r_best_d;
   logic [ACC_W-1:0]  r_best_sad;
   logic              r_issue_done;

   logic              w_accept, w_issue, w_take, w_win_last, w_raster_last, w_load_last;
   logic [ROW_W-1:0]  w_minr, w_maxr;
   logic [COL_W-1:0]  w_minc, w_maxc;
   logic [DISP_W-1:0] w_maxd, w_best_d;
   logic [ADDR_W-1:0] w_left_addr, w_right_addr;
   logic [1:0]                   w_ram_we;
   logic [1:0][ADDR_W-1:0]       w_ram_addr;
   logic [1:0][PIX_W-1:0]        w_ram_rd;
   logic [ACC_W-1:0]  w_sad;

   assign w_accept      = r_load_ready & buffer_ready;
   assign w_issue       = (r_state == ACCUM) && !r_issue_done;
   assign w_win_last    = (r_x == r_maxc) && (r_y == r_maxr);
   assign w_raster_last = (r_row == ROW_W'(HEIGHT - 1)) && (r_col == COL_W'(WIDTH - 1));
   assign w_load_last   = (r_load_addr == ADDR_W'(DEPTH - 1));
   assign w_take        = (r_d == '0) || (w_sad < r_best_sad);
   assign w_best_d      = w_take ? r_d : r_best_d;

   // Window is clipped to the frame; the search range is clipped so x+d stays in-frame.
   always_comb begin
      int v_row;
      int v_col;
      int v_maxc;
      v_row  = int'(r_row);
      v_col  = int'(r_col);
      v_maxc = (v_col + HALF_BLOCK < WIDTH) ? v_col + HALF_BLOCK : WIDTH - 1;
      w_minr = ROW_W'((v_row >= HALF_BLOCK) ? v_row - HALF_BLOCK : 0);
      w_maxr = ROW_W'((v_row + HALF_BLOCK < HEIGHT) ? v_row + HALF_BLOCK : HEIGHT - 1);
      w_minc = COL_W'((v_col >= HALF_BLOCK) ? v_col - HALF_BLOCK : 0);
      w_maxc = COL_W'(v_maxc);
      w_maxd = DISP_W'((WIDTH - 1 - v_maxc < SEARCH_RANGE) ? WIDTH - 1 - v_maxc : SEARCH_RANGE);
   end

   assign w_right_addr = ADDR_W'(int'(r_y) * WIDTH + int'(r_x));
   assign w_left_addr  = ADDR_W'(int'(r_y) * WIDTH + int'(r_x) + int'(r_d));

   // Index 0 holds the left frame, index 1 the right; both share the load counter.
   always_comb begin
      w_ram_we[0]   = (r_state == LOAD_L) && w_accept;
      w_ram_we[1]   = (r_state == LOAD_R) && w_accept;
      w_ram_addr[0] = (r_state == ACCUM) ? w_left_addr  : r_load_addr;
      w_ram_addr[1] = (r_state == ACCUM) ? w_right_addr : r_load_addr;
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_frame_ram
         logic [PIX_W-1:0] r_mem [DEPTH];
         logic [PIX_W-1:0] r_rd;
         always_ff @(posedge clk) begin
            if (w_ram_we[gi]) r_mem[w_ram_addr[gi]] <= image_data;
            r_rd <= r_mem[w_ram_addr[gi]];
         end
         assign w_ram_rd[gi] = r_rd;
      end
   endgenerate

   sad_accum #(
      .PIX_W      (PIX_W),
      .HALF_BLOCK (HALF_BLOCK),
      .ACC_W      (ACC_W)
   ) u_sad_accum (
      .clk     (clk),
      .reset   (reset),
      .i_clear ((r_state == SETUP) || (r_state == COMPARE)),
      .i_en    (w_issue),
      .i_left  (w_ram_rd[0]),
      .i_right (w_ram_rd[1]),
      .o_sad   (w_sad)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_image_sel  <= 1'b0;
         r_load_ready <= 1'b0;
         r_disp_valid <= 1'b0;
         r_disp_last  <= 1'b0;
         r_disp_data  <= '0;
         r_idle       <= 1'b1;
         r_load_addr  <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_minr       <= '0;
         r_maxr       <= '0;
         r_minc       <= '0;
         r_maxc       <= '0;
         r_y          <= '0;
         r_x          <= '0;
         r_d          <= '0;
         r_maxd       <= '0;
         r_best_d     <= '0;
         r_best_sad   <= '0;
         r_issue_done <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state      <= LOAD_L;
                  r_idle       <= 1'b0;
                  r_load_ready <= 1'b1;
                  r_image_sel  <= 1'b0;
                  r_load_addr  <= '0;
               end
            end
            LOAD_L: begin
               if (w_accept) begin
                  if (w_load_last) begin
                     r_load_addr <= '0;
                     r_image_sel <= 1'b1;
                     r_state     <= LOAD_R;
                  end else begin
                     r_load_addr <= r_load_addr + 1'b1;
                  end
               end
            end
            LOAD_R: begin
               if (w_accept) begin
                  if (w_load_last) begin
                     r_load_addr  <= '0;
                     r_load_ready <= 1'b0;
                     r_row        <= '0;
                     r_col        <= '0;
                     r_state      <= SETUP;
                  end else begin
                     r_load_addr <= r_load_addr + 1'b1;
                  end
               end
            end
            SETUP: begin
               r_minr       <= w_minr;
               r_maxr       <= w_maxr;
               r_minc       <= w_minc;
               r_maxc       <= w_maxc;
               r_maxd       <= w_maxd;
               r_y          <= w_minr;
               r_x          <= w_minc;
               r_d          <= '0;
               r_issue_done <= 1'b0;
               r_state      <= ACCUM;
            end
            ACCUM: begin
               // One extra cycle after the last issue lets the final pair land in the accumulator.
               if (!r_issue_done) begin
                  if (w_win_last) begin
                     r_issue_done <= 1'b1;
                  end else if (r_x == r_maxc) begin
                     r_x <= r_minc;
                     r_y <= r_y + 1'b1;
                  end else begin
                     r_x <= r_x + 1'b1;
                  end
               end else begin
                  r_state <= COMPARE;
               end
            end
            COMPARE: begin
               if (w_take) begin
                  r_best_sad <= w_sad;
                  r_best_d   <= r_d;
               end
               if (r_d == r_maxd) begin
                  r_disp_data  <= w_best_d;
                  r_disp_valid <= 1'b1;
                  r_disp_last  <= w_raster_last;
                  r_state      <= EMIT;
               end else begin
                  r_d          <= r_d + 1'b1;
                  r_y          <= r_minr;
                  r_x          <= r_minc;
                  r_issue_done <= 1'b0;
                  r_state      <= ACCUM;
               end
            end
            EMIT: begin
               if (disp_ready) begin
                  r_disp_valid <= 1'b0;
                  r_disp_last  <= 1'b0;
                  if (r_disp_last) begin
                     r_idle  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     if (r_col == COL_W'(WIDTH - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                     end else begin
                        r_col <= r_col + 1'b1;
                     end
                     r_state <= SETUP;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign image_sel  = r_image_sel;
   assign load_ready = r_load_ready;
   assign disp_data  = r_disp_data;
   assign disp_valid = r_disp_valid;
   assign disp_last  = r_disp_last;
   assign idle       = r_idle;

endmodule

// File: tb/tb_disparity_sad_engine.sv
// Scoreboard bench: stimulus queues hand-computed disparities, a negedge monitor checks each transfer.
module tb_disparity_sad_engine;

   localparam int W = 8;
   localparam int H = 4;
   localparam int N = W * H;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] image_data = 8'h00;
   logic       buffer_ready = 1'b0;
   logic       disp_ready = 1'b1;
   logic       image_sel, load_ready, disp_valid, disp_last, idle;
   logic [7:0] disp_data;

   exp_t       sb[$];
   logic [7:0] frame_l [N];
   logic [7:0] frame_r [N];
   logic [7:0] shift_col [W] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0};

   int  n_checks = 0;
   int  n_pass = 0;
   int  n_out = 0;
   bit  bp_mode = 1'b0;
   int  bp_cnt = 0;
   bit  hold_pending = 1'b0;
   logic [7:0] held_data;
   logic       held_last;

   always #5 clk = ~clk;

   disparity_sad_engine #(
      .WIDTH        (W),
      .HEIGHT       (H),
      .PIX_W        (8),
      .HALF_BLOCK   (1),
      .SEARCH_RANGE (3),
      .DISP_W       (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .image_data   (image_data),
      .buffer_ready (buffer_ready),
      .image_sel    (image_sel),
      .load_ready   (load_ready),
      .disp_data    (disp_data),
      .disp_valid   (disp_valid),
      .disp_ready   (disp_ready),
      .disp_last    (disp_last),
      .idle         (idle)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic make_shift();
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            frame_r[r*W+c] = 8'(16 * c + r);
            frame_l[r*W+c] = (c >= 2) ? 8'(16 * (c - 2) + r) : 8'hFF;
         end
      end
   endtask

   task automatic make_same();
      for (int i = 0; i < N; i++) begin
         frame_r[i] = 8'($urandom_range(0, 255));
         frame_l[i] = frame_r[i];
      end
   endtask

   task automatic push_expected(input bit shifted);
      exp_t e;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            e.data = shifted ? shift_col[c] : 8'd0;
            e.last = (r == H - 1) && (c == W - 1);
            sb.push_back(e);
         end
      end
   endtask

   task automatic start();
      @(posedge clk); #1 enable = 1'b1;
      @(posedge clk); #1 enable = 1'b0;
   endtask

   task automatic load_pair(input bit stall, input string name);
      int idx = 0;
      int k = 0;
      int cyc = 0;
      int extra = 0;
      while (idx < 2 * N && cyc < 2000) begin
         @(posedge clk); #1;
         buffer_ready = stall ? (k % 3 == 0) : 1'b1;
         image_data   = (idx < N) ? frame_l[idx] : frame_r[idx-N];
         k++;
         @(negedge clk);
         if (load_ready && buffer_ready) begin
            check({name, "_image_sel"}, int'(image_sel), (idx >= N) ? 1 : 0);
            idx++;
         end
         cyc++;
      end
      check({name, "_pixels"}, idx, 2 * N);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 buffer_ready = 1'b1;
         @(negedge clk);
         if (load_ready) extra++;
      end
      @(posedge clk); #1 buffer_ready = 1'b0;
      check({name, "_extra_pixels"}, extra, 0);
   endtask

   task automatic wait_outputs(input int target, input string name);
      int cyc = 0;
      while (n_out < target && cyc < 6000) begin
         @(posedge clk);
         cyc++;
      end
      check({name, "_outputs"}, n_out, target);
   endtask

   // Output-side ready driver: stalls output index 5 for 10 cycles when bp_mode is set.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (bp_mode && n_out == 5 && disp_valid && bp_cnt < 10) begin
            disp_ready = 1'b0;
            bp_cnt++;
         end else begin
            disp_ready = 1'b1;
         end
      end
   end

   // Monitor: every transfer pops one expectation; held outputs must not change.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_pending = 1'b0;
         end else begin
            if (hold_pending) begin
               check("hold_valid", int'(disp_valid), 1);
               check("hold_data", int'(disp_data), int'(held_data));
               check("hold_last", int'(disp_last), int'(held_last));
            end
            if (disp_valid && disp_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", int'(disp_data), -1);
               end else begin
                  e = sb.pop_front();
                  $display("out %0d: data=%0d last=%0d (expect data=%0d last=%0d)",
                           n_out, disp_data, disp_last, e.data, e.last);
                  check("disp_data", int'(disp_data), int'(e.data));
                  check("disp_last", int'(disp_last), int'(e.last));
               end
               n_out++;
               hold_pending = 1'b0;
            end else if (disp_valid) begin
               hold_pending = 1'b1;
               held_data    = disp_data;
               held_last    = disp_last;
            end else begin
               hold_pending = 1'b0;
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_idle", int'(idle), 1);
      check("rst_image_sel", int'(image_sel), 0);
      check("rst_load_ready", int'(load_ready), 0);
      check("rst_disp_valid", int'(disp_valid), 0);
      check("rst_disp_data", int'(disp_data), 0);
      check("rst_disp_last", int'(disp_last), 0);
      reset = 1'b0;

      // Shifted pair, no stalls.
      make_shift();
      n_out = 0;
      push_expected(1'b1);
      start();
      load_pair(1'b0, "shift");
      wait_outputs(N, "shift");
      #1;
      check("shift_sb_left", sb.size(), 0);
      check("shift_idle", int'(idle), 1);
      check("shift_valid_drop", int'(disp_valid), 0);

      // Identical frames resolve every tie to disparity 0.
      make_same();
      n_out = 0;
      push_expected(1'b0);
      start();
      load_pair(1'b0, "same");
      wait_outputs(N, "same");
      check("same_sb_left", sb.size(), 0);

      // Stalled load plus output backpressure.
      make_shift();
      n_out = 0;
      bp_cnt = 0;
      bp_mode = 1'b1;
      push_expected(1'b1);
      start();
      load_pair(1'b1, "stall");
      wait_outputs(N, "stall");
      bp_mode = 1'b0;
      check("bp_cycles", bp_cnt, 10);
      check("stall_sb_left", sb.size(), 0);

      // Reset after 12 outputs, then a full rerun.
      n_out = 0;
      push_expected(1'b1);
      start();
      load_pair(1'b0, "pre_reset");
      wait_outputs(12, "pre_reset");
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("mid_rst_idle", int'(idle), 1);
      check("mid_rst_valid", int'(disp_valid), 0);
      sb.delete();
      n_out = 0;
      push_expected(1'b1);
      start();
      load_pair(1'b0, "post_reset");
      wait_outputs(N, "post_reset");
      check("post_reset_sb_left", sb.size(), 0);

      // enable pulsed while computing must not start a second pair.
      n_out = 0;
      push_expected(1'b1);
      start();
      load_pair(1'b0, "busy_en");
      repeat (2) @(posedge clk);
      #1 enable = 1'b1;
      repeat (4) @(posedge clk);
      #1 enable = 1'b0;
      wait_outputs(N, "busy_en");
      repeat (300) @(posedge clk);
      #1;
      check("busy_en_idle", int'(idle), 1);
      check("busy_en_outputs", n_out, N);
      check("busy_en_load_ready", int'(load_ready), 0);
      check("busy_en_sb_left", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
